// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus: instruction memory request/ack channel plus the prefetch-buffer head seen by decode.
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int COUNT_W = $clog2(DEPTH) + 1;

  logic                  o_MemRequest;
  logic [ADDR_WIDTH-1:0] o_MemAddress;
  logic                  i_MemAck;
  logic [31:0]           i_MemData;
  logic                  i_Redirect;
  logic [ADDR_WIDTH-1:0] i_RedirectAddress;
  logic                  o_Valid;
  logic [31:0]           o_InstructionWord;
  logic [ADDR_WIDTH-1:0] o_InstructionPointer;
  logic                  i_Ready;
  logic [COUNT_W-1:0]    o_Count;

  modport master (
    output o_MemRequest, o_MemAddress, o_Valid, o_InstructionWord,
           o_InstructionPointer, o_Count,
    input  i_MemAck, i_MemData, i_Redirect, i_RedirectAddress, i_Ready
  );

  modport slave (
    input  o_MemRequest, o_MemAddress, o_Valid, o_InstructionWord,
           o_InstructionPointer, o_Count,
    output i_MemAck, i_MemData, i_Redirect, i_RedirectAddress, i_Ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction prefetch unit: one outstanding memory request feeding a circular buffer of
// {word, address} entries, with flush-and-refetch on branch redirect.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DEPTH        = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                i_Clock,
  input  logic                i_Reset,
  instruction_fetch_if.master bus
);
  localparam int                 PTR_W   = $clog2(DEPTH);
  localparam int                 COUNT_W = PTR_W + 1;
  localparam logic [COUNT_W-1:0] FULL    = COUNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} fetchState_t;

  fetchState_t           state, stateNext;
  logic [ADDR_WIDTH-1:0] fetchAddr;
  logic [ADDR_WIDTH-1:0] discardAddr;
  logic [ADDR_WIDTH-1:0] redirectAligned;
  logic [PTR_W-1:0]      wrPtr, rdPtr;
  logic [COUNT_W-1:0]    count, countNext;
  logic                  push, pop;
  logic [31:0]           wordMem [DEPTH];
  logic [ADDR_WIDTH-1:0] addrMem [DEPTH];

  assign redirectAligned = bus.i_RedirectAddress & ~ADDR_WIDTH'(3);

  // A redirect squashes both the pending ack data and any decode pop in that cycle.
  assign push = (state == WAIT) && bus.i_MemAck && !bus.i_Redirect;
  assign pop  = (count != '0) && bus.i_Ready && !bus.i_Redirect;

  always_comb begin
    countNext = count;
    if (bus.i_Redirect) begin
      countNext = '0;
    end else if (push && !pop) begin
      countNext = count + COUNT_W'(1);
    end else if (pop && !push) begin
      countNext = count - COUNT_W'(1);
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (!bus.i_Redirect && (count < FULL)) stateNext = WAIT;
      end
      WAIT: begin
        if (bus.i_Redirect) begin
          stateNext = bus.i_MemAck ? IDLE : DISCARD;
        end else if (bus.i_MemAck && (countNext >= FULL)) begin
          stateNext = IDLE;
        end
      end
      DISCARD: begin
        // The abandoned request must complete before a new one may issue.
        if (bus.i_MemAck) stateNext = WAIT;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state     <= IDLE;
      fetchAddr <= RESET_VECTOR;
      count     <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
    end else begin
      state <= stateNext;
      count <= countNext;
      if (bus.i_Redirect) begin
        fetchAddr <= redirectAligned;
        wrPtr     <= '0;
        rdPtr     <= '0;
      end else begin
        if (push) begin
          fetchAddr <= fetchAddr + ADDR_WIDTH'(4);
          wrPtr     <= wrPtr + PTR_W'(1);
        end
        if (pop) rdPtr <= rdPtr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push) begin
      wordMem[wrPtr] <= bus.i_MemData;
      addrMem[wrPtr] <= fetchAddr;
    end
    if ((state == WAIT) && bus.i_Redirect && !bus.i_MemAck) discardAddr <= fetchAddr;
  end

  assign bus.o_MemRequest         = (state != IDLE);
  assign bus.o_MemAddress         = (state == DISCARD) ? discardAddr : fetchAddr;
  assign bus.o_Valid              = (count != '0);
  assign bus.o_InstructionWord    = wordMem[rdPtr];
  assign bus.o_InstructionPointer = addrMem[rdPtr];
  assign bus.o_Count              = count;
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Parameters
REQ-001 SHALL provide ADDR_WIDTH, default 32, instruction address width.
REQ-002 SHALL provide DEPTH, default 4, prefetch buffer entries; power of two, >=2.
REQ-003 SHALL provide RESET_VECTOR, default 0, first fetch address after reset; bits[1:0] zero.

Interface
REQ-004 SHALL have i_Clock  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have i_Reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have o_MemRequest  output  1  fetch request to instruction memory, held until i_MemAck.
REQ-007 SHALL have o_MemAddress  output  ADDR_WIDTH  word-aligned fetch address, stable while o_MemRequest is high.
REQ-008 SHALL have i_MemAck  input  1  one-cycle pulse: i_MemData valid, request complete.
REQ-009 SHALL have i_MemData  input  32  instruction word returned with i_MemAck.
REQ-010 SHALL have i_Redirect  input  1  one-cycle pulse from branch/jump resolution: flush and refetch.
REQ-011 SHALL have i_RedirectAddress  input  ADDR_WIDTH  new fetch address; bits[1:0] ignored (forced zero).
REQ-012 SHALL have o_Valid  output  1  buffer head holds a valid instruction.
REQ-013 SHALL have o_InstructionWord  output  32  buffer head instruction word.
REQ-014 SHALL have o_InstructionPointer  output  ADDR_WIDTH  address of buffer head instruction.
REQ-015 SHALL have i_Ready  input  1  decode consumes head when o_Valid && i_Ready.
REQ-016 SHALL have o_Count  output  $clog2(DEPTH)+1  number of buffered entries.

Function
REQ-017 SHALL hold a circular FIFO of DEPTH {word, address} entries; read/write pointers wrap modulo DEPTH.
REQ-018 SHALL drive o_Valid = (o_Count != 0); o_InstructionWord/o_InstructionPointer combinationally from head entry.
REQ-019 SHALL keep fetch address register FA; FA += 4 on each accepted ack, wrapping modulo 2^ADDR_WIDTH.
REQ-020 SHALL implement FSM states IDLE, WAIT, DISCARD; o_MemRequest = 1 in WAIT and DISCARD only.
REQ-021 SHALL drive o_MemAddress = FA in WAIT; in DISCARD, the address of the abandoned request (latched).
REQ-022 SHALL allow at most one outstanding memory request.
REQ-023 IDLE -> WAIT SHALL occur when o_Count < DEPTH and i_Redirect = 0; first request visible one cycle after the condition.
REQ-024 WAIT on i_MemAck without redirect SHALL push {i_MemData, FA}, advance FA, stay WAIT if post-update count < DEPTH else go IDLE.
REQ-025 Sustained throughput with single-cycle ack SHALL be one instruction per cycle.
REQ-026 Pop (o_Valid && i_Ready) and push in the same cycle SHALL both take effect; count unchanged.
REQ-027 Push SHALL never occur when full; request issue is gated so the slot is reserved.
REQ-028 i_Redirect SHALL flush the FIFO (count 0, pointers reset) next cycle and load FA with the redirect address; simultaneous pop ignored.
REQ-029 i_Redirect in WAIT without same-cycle ack SHALL go DISCARD.
REQ-030 i_Redirect with same-cycle i_MemAck SHALL discard the ack data and go IDLE.
REQ-031 DISCARD on i_MemAck SHALL drop i_MemData without pushing and go WAIT (fetch from FA).
REQ-032 i_Redirect while in DISCARD SHALL update FA and remain DISCARD.
REQ-033 i_MemAck while IDLE SHALL be ignored.

Reset
REQ-034 When i_Reset is high at a rising edge: state IDLE, FA = RESET_VECTOR, count 0, pointers 0, o_Valid 0, o_MemRequest 0.
REQ-035 Reset SHALL take priority over redirect, ack and pop; a request in flight is abandoned and its later ack ignored per REQ-033.

Verification
REQ-036 Reset, RESET_VECTOR=0x100, ack 1 cycle after each request, i_Ready=1 -> words at 0x100,0x104,0x108 delivered in order, one per cycle once streaming.
REQ-037 DEPTH=4, i_Ready=0, immediate acks -> exactly 4 pushes, o_Count=4, o_MemRequest low; raising i_Ready for 1 cycle -> one new request at FA=0x10 (from 0).
REQ-038 Redirect to 0x200 while request to 0x8 outstanding, ack 3 cycles later -> ack data dropped, count stays 0, next request addresses 0x200.
REQ-039 Redirect to 0x203 coinciding with ack -> data dropped, state IDLE, next request addresses 0x200.
REQ-040 FA=0xFFFFFFFC, ADDR_WIDTH=32, two acks -> entries at 0xFFFFFFFC then 0x00000000.
REQ-041 Reset asserted during WAIT, ack arrives one cycle after reset -> no push, o_Valid 0, next request addresses RESET_VECTOR.
